// File: rtl/weight_mem_pkg.sv
// weight_mem_pkg: shared widths, weight addresses, reset contents and write-FSM state type
package weight_mem_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int W12_ADDR = 0;
  localparam int W34_ADDR = 1;
  localparam logic [7:0] W12_RST = 8'h11;
  localparam logic [7:0] W34_RST = 8'h1F;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_ACK    = 2'd2
  } wr_state_e;
  function automatic logic [7:0] rst_word(input int a);
    return a == W12_ADDR ? W12_RST : a == W34_ADDR ? W34_RST : 8'h00;
  endfunction
endpackage

// File: rtl/weight_regfile.sv
// weight_regfile: weight storage with reset contents; rdata sees a same-cycle write (clk, rst, we/waddr/wdata write port, raddr/rdata read port)
module weight_regfile
  import weight_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  assign rdata = mem_d[raddr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < DEPTH; i++) mem_q[i] <= DW'(rst_word(i));
    else mem_q <= mem_d;
  end
endmodule

// File: rtl/weight_mem_responder.sv
// weight_mem_responder: 1-cycle read port (w_req/w_addr -> w_valid/w_data) and 3-state write port (wb_req/wb_addr/wb_wdata -> wb_ack) with saturating wr_count
module weight_mem_responder
  import weight_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  output logic              w_valid,
  output logic [DW-1:0]     w_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DW-1:0]     wb_wdata,
  output logic              wb_ack,
  output logic [7:0]        wr_count
);
  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic              wb_ack_q, wb_ack_d;
  logic              w_valid_q, w_valid_d;
  logic [DW-1:0]     w_data_q, w_data_d;
  logic [DW-1:0]     rd_data;
  logic              we;
  weight_regfile #(.ADDR_W(ADDR_W), .DW(DW), .DEPTH(DEPTH)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (addr_q),
    .wdata (data_q),
    .raddr (w_addr),
    .rdata (rd_data)
  );
  assign we = state_q == S_COMMIT;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      S_IDLE: if (wb_req) begin
        state_d = S_COMMIT;
        addr_d = wb_addr;
        data_d = wb_wdata;
      end
      S_COMMIT: state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase
    wr_count_d = we && wr_count_q != 8'hFF ? wr_count_q + 8'd1 : wr_count_q;
    wb_ack_d = we;
    w_valid_d = w_req;
    w_data_d = w_req ? rd_data : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
      wr_count_q <= '0;
      wb_ack_q <= 1'b0;
      w_valid_q <= 1'b0;
      w_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_count_q <= wr_count_d;
      wb_ack_q <= wb_ack_d;
      w_valid_q <= w_valid_d;
      w_data_q <= w_data_d;
    end
  end
  assign w_valid = w_valid_q;
  assign w_data = w_data_q;
  assign wb_ack = wb_ack_q;
  assign wr_count = wr_count_q;
endmodule
